// File: rtl/tub_scan_driver.sv
// Two-digit segment scan driver.
// Shows the sign digit and then the absolute-value digit on one shared segment
// bus, with an all-off gap after each digit to suppress ghosting. Both segment
// patterns are captured into shadow registers once per frame, so a digit cannot
// change while it is on the bus.
module tub_scan_driver #(
  parameter int SHOW_CYC  = 4,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] tub_sflag_control,
  input  logic [7:0] tub_sabsolut_control,
  output logic [1:0] tub_sel,
  output logic [7:0] tub_control,
  output logic       frame_done
);

  localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } scan_state_e;

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shadow_flag_q, shadow_flag_d;
  logic [7:0]       shadow_abs_q, shadow_abs_d;
  logic             frame_done_q, frame_done_d;

  // State, dwell counter, shadow patterns and frame pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SHOW0;
      cnt_q         <= CNT_ZERO;
      shadow_flag_q <= 8'h00;
      shadow_abs_q  <= 8'h00;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shadow_flag_q <= shadow_flag_d;
      shadow_abs_q  <= shadow_abs_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Scan sequencing: advance through the four phases, reload shadows at the frame wrap.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shadow_flag_d = shadow_flag_q;
    shadow_abs_d  = shadow_abs_q;
    frame_done_d  = 1'b0;

    if (!en) begin
      // Disabled: park at frame start and keep tracking the inputs so the
      // first enabled cycle already shows current data.
      state_d       = SHOW0;
      cnt_d         = CNT_ZERO;
      shadow_flag_d = tub_sflag_control;
      shadow_abs_d  = tub_sabsolut_control;
    end else begin
      case (state_q)
        SHOW0: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK0;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        BLANK0: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW1;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        SHOW1: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK1;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        BLANK1: begin
          if (cnt_q == BLANK_LAST) begin
            // Frame boundary: the only enabled point where new data is taken.
            state_d       = SHOW0;
            cnt_d         = CNT_ZERO;
            shadow_flag_d = tub_sflag_control;
            shadow_abs_d  = tub_sabsolut_control;
            frame_done_d  = 1'b1;
          end else begin
            cnt_d         = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = SHOW0;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Digit select and segment bus decode; dark whenever disabled or blanking.
  always_comb begin
    tub_sel     = 2'b00;
    tub_control = 8'h00;
    if (!en) begin
      tub_sel     = 2'b00;
      tub_control = 8'h00;
    end else begin
      case (state_q)
        SHOW0: begin
          tub_sel     = 2'b01;
          tub_control = shadow_flag_q;
        end
        SHOW1: begin
          tub_sel     = 2'b10;
          tub_control = shadow_abs_q;
        end
        BLANK0, BLANK1: begin
          tub_sel     = 2'b00;
          tub_control = 8'h00;
        end
        default: begin
          tub_sel     = 2'b00;
          tub_control = 8'h00;
        end
      endcase
    end
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tub_scan_driver.sv
// Self-checking bench for tub_scan_driver: a directed vector table, hand-written
// corner sequences, a 64-combination sweep through a stand-in upstream stage and
// a randomized run, all compared against a frame-position reference model.
module tb_tub_scan_driver;

  localparam int SHOW  = 4;
  localparam int BLANK = 2;
  localparam int FRAME = 2 * (SHOW + BLANK);
  localparam int NVEC  = 26;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] flag_in = 8'h00;
  logic [7:0] abs_in = 8'h00;
  logic [1:0] sel;
  logic [7:0] ctrl;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position within the frame plus the latched patterns.
  int         m_pos = 0;
  logic [7:0] m_flag = 8'h00;
  logic [7:0] m_abs = 8'h00;
  logic       m_done = 1'b0;

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] f;
    logic [7:0] a;
    logic [1:0] x_sel;
    logic [7:0] x_ctrl;
    logic       x_done;
  } vec_t;

  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  tub_scan_driver #(.SHOW_CYC(SHOW), .BLANK_CYC(BLANK)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .en                   (en),
    .tub_sflag_control    (flag_in),
    .tub_sabsolut_control (abs_in),
    .tub_sel              (sel),
    .tub_control          (ctrl),
    .frame_done           (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t pos=%0d)", name, act, exp, $time, m_pos);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic [7:0] f, input logic [7:0] a);
    if (r) begin
      m_pos = 0; m_flag = 8'h00; m_abs = 8'h00; m_done = 1'b0;
    end else if (!e) begin
      m_pos = 0; m_flag = f; m_abs = a; m_done = 1'b0;
    end else if (m_pos == FRAME - 1) begin
      m_pos = 0; m_flag = f; m_abs = a; m_done = 1'b1;
    end else begin
      m_pos = m_pos + 1; m_done = 1'b0;
    end
  endtask

  task automatic check_model();
    logic [1:0] xs;
    logic [7:0] xc;
    xs = 2'b00; xc = 8'h00;
    if (en) begin
      if (m_pos < SHOW) begin
        xs = 2'b01; xc = m_flag;
      end else if (m_pos >= SHOW + BLANK && m_pos < 2 * SHOW + BLANK) begin
        xs = 2'b10; xc = m_abs;
      end
    end
    check("model_sel", {30'd0, sel}, {30'd0, xs});
    check("model_ctrl", {24'd0, ctrl}, {24'd0, xc});
    check("model_done", {31'd0, done}, {31'd0, m_done});
    check("inv_sel_not_11", {31'd0, (sel == 2'b11)}, 32'd0);
    check("inv_dark_when_unselected", {31'd0, (sel == 2'b00 && ctrl != 8'h00)}, 32'd0);
  endtask

  // One clock: drive inputs, advance the model at the edge, check away from the edge.
  task automatic tick(input logic r, input logic e, input logic [7:0] f, input logic [7:0] a);
    rst = r; en = e; flag_in = f; abs_in = a;
    @(posedge clk);
    model_step(r, e, f, a);
    @(negedge clk);
    check_model();
  endtask

  // Stand-in for the upstream stage: sign and magnitude of a-b on 7-seg patterns.
  function automatic logic [15:0] upstream(input int a, input int b);
    logic [7:0] seg [8];
    int d;
    seg[0] = 8'h3F; seg[1] = 8'h06; seg[2] = 8'h5B; seg[3] = 8'h4F;
    seg[4] = 8'h66; seg[5] = 8'h6D; seg[6] = 8'h7D; seg[7] = 8'h07;
    d = a - b;
    if (d < 0) return {8'h40, seg[-d]};
    else       return {8'h00, seg[d]};
  endfunction

  initial begin
    logic [1:0] sel_pat [FRAME];
    logic [7:0] ctl_pat [FRAME];
    logic       seen_wrap;
    logic [15:0] up;
    logic        r_e;
    logic [7:0]  r_f, r_a;

    sel_pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    ctl_pat = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00,
                8'h60, 8'h60, 8'h60, 8'h60, 8'h00, 8'h00};

    // Vector table: reset edge, then en=1 with constant 02/60. Entry i is the
    // state after edge i; the first frame shows cleared shadows.
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].r      = (i == 0);
      vecs[i].e      = 1'b1;
      vecs[i].f      = 8'h02;
      vecs[i].a      = 8'h60;
      vecs[i].x_sel  = sel_pat[i % FRAME];
      vecs[i].x_ctrl = (i < FRAME) ? 8'h00 : ctl_pat[i % FRAME];
      vecs[i].x_done = (i > 0) && (i % FRAME == 0);
    end

    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].r; en = vecs[i].e; flag_in = vecs[i].f; abs_in = vecs[i].a;
      @(posedge clk);
      model_step(vecs[i].r, vecs[i].e, vecs[i].f, vecs[i].a);
      @(negedge clk);
      check("vec_sel", {30'd0, sel}, {30'd0, vecs[i].x_sel});
      check("vec_ctrl", {24'd0, ctrl}, {24'd0, vecs[i].x_ctrl});
      check("vec_done", {31'd0, done}, {31'd0, vecs[i].x_done});
    end

    // abs changes mid-SHOW1: old value until the wrap, new value afterwards.
    for (int k = 0; k < FRAME && m_pos != SHOW + BLANK + 1; k++) tick(1'b0, 1'b1, 8'h02, 8'h60);
    seen_wrap = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick(1'b0, 1'b1, 8'h02, 8'hDA);
      if (m_pos == 0) seen_wrap = 1'b1;
      if (sel == 2'b10) check("abs_change_frame", {24'd0, ctrl}, seen_wrap ? 32'h0000_00DA : 32'h0000_0060);
    end

    // en low for 5 cycles mid-SHOW1, then re-enable with a new flag value.
    for (int k = 0; k < FRAME && m_pos != SHOW + BLANK + 1; k++) tick(1'b0, 1'b1, 8'h02, 8'hDA);
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b0, 8'h3F, 8'hDA);
      check("en_low_sel", {30'd0, sel}, 32'd0);
      check("en_low_ctrl", {24'd0, ctrl}, 32'd0);
      check("en_low_done", {31'd0, done}, 32'd0);
    end
    en = 1'b1;
    #1;
    check("reen_first_sel", {30'd0, sel}, 32'd1);
    check("reen_first_ctrl", {24'd0, ctrl}, 32'h0000_003F);
    for (int k = 1; k <= SHOW; k++) begin
      tick(1'b0, 1'b1, 8'h3F, 8'hDA);
      check("reen_dwell_sel", {30'd0, sel}, (k < SHOW) ? 32'd1 : 32'd0);
    end

    // Reset asserted during BLANK0.
    for (int k = 0; k < FRAME && m_pos != SHOW; k++) tick(1'b0, 1'b1, 8'h3F, 8'hDA);
    tick(1'b1, 1'b1, 8'h3F, 8'hDA);
    check("rst_blank0_sel", {30'd0, sel}, 32'd1);
    check("rst_blank0_ctrl", {24'd0, ctrl}, 32'd0);
    check("rst_blank0_done", {31'd0, done}, 32'd0);
    for (int k = 1; k <= SHOW; k++) begin
      tick(1'b0, 1'b1, 8'h3F, 8'hDA);
      check("rst_restart_sel", {30'd0, sel}, (k < SHOW) ? 32'd1 : 32'd0);
    end

    // Sweep all 64 {a,b} pairs through the upstream stand-in, one frame each.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        up = upstream(a, b);
        for (int k = 0; k < FRAME; k++) tick(1'b0, 1'b1, up[15:8], up[7:0]);
      end
    end

    // Randomized run with occasional resets, enable drops and data changes.
    r_e = 1'b1; r_f = 8'h00; r_a = 8'h00;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(15, 0) == 0) r_e = ~r_e;
      if ($urandom_range(7, 0) == 0) r_f = 8'($urandom);
      if ($urandom_range(7, 0) == 0) r_a = 8'($urandom);
      tick(($urandom_range(63, 0) == 0), r_e, r_f, r_a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
